// File: rtl/ahb_timer.sv
// ahb_timer: AHB slave down-counting timer with a periodic or one-shot tick
// and a level interrupt.
// Build option: TIMER_PRESCALER_EN adds the PRESCALE register and the
// prescale counter. Without it, the counter ticks on every enabled clock.
// In that build PRESCALE is still a mapped register, but it reads 0 and
// ignores writes.
// Register map (HADDR[4:2]):
//   0 CTRL     [0]enable [1]auto_reload [2]irq_en
//   1 LOAD
//   2 VALUE    read-only
//   3 STATUS   [0]expired, write 1 to clear
//   4 PRESCALE
module ahb_timer #(
  parameter int          PRESCALE_W = 8,
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        HSEL_i,
  input  logic [1:0]  HTRANS_i,
  input  logic        HWRITE_i,
  input  logic [2:0]  HSIZE_i,
  input  logic [31:0] HADDR_i,
  input  logic [31:0] HWDATA_i,
  output logic        HREADY_o,
  output logic [1:0]  HRESP_o,
  output logic [15:0] HSPLIT_o,
  output logic [31:0] HRDATA_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_e;

  localparam logic [2:0] IDX_CTRL = 3'd0, IDX_LOAD = 3'd1, IDX_VALUE = 3'd2,
                         IDX_STATUS = 3'd3, IDX_PSC = 3'd4;

  state_e          state_q;
  logic            hready_q;
  logic [1:0]      hresp_q;
  logic            dp_vld_q, dp_wr_q;
  logic [2:0]      dp_idx_q;

  logic [2:0]      ctrl_q, ctrl_d;
  logic [31:0]     load_q, load_d;
  logic [31:0]     value_q, value_d;
  logic            expired_q, expired_d;
  logic [PRESCALE_W-1:0] prescale_q;
  logic            tick;

  logic [2:0]      a_idx;
  logic            accept, illegal;
  logic            wr, wr_ctrl, wr_load, wr_status;
  logic [31:0]     rdata;

  // The upper address bits, the byte-offset bits and HTRANS[0] are
  // intentionally ignored.
  wire unused_ok = ^{HADDR_i[31:5], HADDR_i[1:0], HTRANS_i[0]};

  assign a_idx    = HADDR_i[4:2];
  assign accept   = HSEL_i & HTRANS_i[1] & hready_q;
  assign illegal  = (a_idx > IDX_PSC) | (HSIZE_i != 3'b010) |
                    (HWRITE_i & (a_idx == IDX_VALUE));

  assign HREADY_o = hready_q;
  assign HRESP_o  = hresp_q;
  assign HSPLIT_o = 16'h0000;

  // Bus FSM. An illegal transfer gets the two-cycle ERROR response and
  // never opens a data phase, so it cannot change any register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      dp_vld_q <= 1'b0;
      dp_wr_q  <= 1'b0;
      dp_idx_q <= 3'd0;
    end else begin
      case (state_q)
        ERR1: begin
          state_q  <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 2'b01;
          dp_vld_q <= 1'b0;
        end
        default: begin  // IDLE or ERR2; both can take a new address phase
          if (accept && illegal) begin
            state_q  <= ERR1;
            hready_q <= 1'b0;
            hresp_q  <= 2'b01;
            dp_vld_q <= 1'b0;
          end else begin
            state_q  <= IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
            dp_vld_q <= accept;
            dp_wr_q  <= HWRITE_i;
            dp_idx_q <= a_idx;
          end
        end
      endcase
    end
  end

  assign wr        = dp_vld_q & dp_wr_q;
  assign wr_ctrl   = wr & (dp_idx_q == IDX_CTRL);
  assign wr_load   = wr & (dp_idx_q == IDX_LOAD);
  assign wr_status = wr & (dp_idx_q == IDX_STATUS);

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_d, psc_q, psc_d;
  logic                  wr_psc;
  assign wr_psc = wr & (dp_idx_q == IDX_PSC);
  assign tick   = ctrl_q[0] & (psc_q == prescale_q);
`else
  assign prescale_q = '0;
  assign tick       = ctrl_q[0];
`endif

  // Timer next state. Bus writes are applied after the counter update, so
  // they take priority. The one exception is the expiry set, which beats a
  // STATUS clear in the same cycle.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    expired_d = expired_q;
`ifdef TIMER_PRESCALER_EN
    prescale_d = prescale_q;
    psc_d      = psc_q;
    if (ctrl_q[0]) psc_d = tick ? '0 : psc_q + 1'b1;
`endif
    if (tick) begin
      if (value_q != 32'd0) value_d = value_q - 32'd1;
      else if (ctrl_q[1])   value_d = load_q;
      else                  ctrl_d[0] = 1'b0;
    end
    if (wr_status && HWDATA_i[0]) expired_d = 1'b0;
    if (tick && value_q == 32'd0) expired_d = 1'b1;
    if (wr_ctrl) begin
      ctrl_d = HWDATA_i[2:0];
`ifdef TIMER_PRESCALER_EN
      if (!ctrl_q[0] && HWDATA_i[0]) psc_d = '0;
`endif
    end
    if (wr_load) begin
      load_d  = HWDATA_i;
      value_d = HWDATA_i;
`ifdef TIMER_PRESCALER_EN
      psc_d   = '0;
`endif
    end
`ifdef TIMER_PRESCALER_EN
    if (wr_psc) prescale_d = HWDATA_i[PRESCALE_W-1:0];
`endif
  end

  // Timer state registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ctrl_q    <= 3'd0;
      load_q    <= RESET_LOAD;
      value_q   <= RESET_LOAD;
      expired_q <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      prescale_q <= '0;
      psc_q      <= '0;
`endif
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      expired_q <= expired_d;
`ifdef TIMER_PRESCALER_EN
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
`endif
    end
  end

  // Read mux from live registers; unused bits read 0
  always_comb begin
    case (dp_idx_q)
      IDX_CTRL:   rdata = {29'd0, ctrl_q};
      IDX_LOAD:   rdata = load_q;
      IDX_VALUE:  rdata = value_q;
      IDX_STATUS: rdata = {31'd0, expired_q};
      IDX_PSC:    rdata = 32'(prescale_q);
      default:    rdata = 32'd0;
    endcase
  end

  assign HRDATA_o = (dp_vld_q & ~dp_wr_q) ? rdata : 32'd0;
  assign irq_o    = expired_q & ctrl_q[2];

endmodule

// File: tb/tb_ahb_timer.sv
// tb_ahb_timer: directed-vector bench for ahb_timer. Inputs are driven 1ns
// after the rising edge, and outputs are sampled on the falling edge.
// Expected values are hand-computed for either build of the prescaler option.
module tb_ahb_timer;

  logic        clk = 1'b0, rst = 1'b1;
  logic        hsel = 1'b0, hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] haddr = '0, hwdata = '0;
  logic        hready, irq;
  logic [1:0]  hresp;
  logic [15:0] hsplit;
  logic [31:0] hrdata;

  int nvec = 0, nerr = 0;

  logic [31:0] s_data;
  logic        s_rdy, s_irq;
  logic [1:0]  s_resp;

  ahb_timer dut (
    .clock_i(clk), .reset_i(rst), .HSEL_i(hsel), .HTRANS_i(htrans),
    .HWRITE_i(hwrite), .HSIZE_i(hsize), .HADDR_i(haddr), .HWDATA_i(hwdata),
    .HREADY_o(hready), .HRESP_o(hresp), .HSPLIT_o(hsplit),
    .HRDATA_o(hrdata), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One transfer: address phase, then one data-phase cycle, sampled mid-cycle
  task automatic xfer(input logic w, input logic [2:0] idx, input logic [2:0] sz,
                      input logic [31:0] wd);
    hsel = 1'b1; htrans = 2'b10; hwrite = w; hsize = sz;
    haddr = {27'h0A5_0000, idx, 2'b00};
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    @(negedge clk);
    s_data = hrdata; s_rdy = hready; s_resp = hresp; s_irq = irq;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    xfer(1'b1, idx, 3'b010, d);
  endtask

  task automatic rd(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    xfer(1'b0, idx, 3'b010, 32'h0);
    chk(tag, s_data, exp);
  endtask

  // Illegal transfer: expect HREADY 0 then 1, with ERROR in both cycles
  task automatic err_xfer(input string tag, input logic w, input logic [2:0] idx,
                          input logic [2:0] sz, input logic [31:0] wd);
    xfer(w, idx, sz, wd);
    chk({tag, "_rdy1"}, 32'(s_rdy), 32'd0);
    chk({tag, "_rsp1"}, 32'(s_resp), 32'd1);
    @(negedge clk);
    chk({tag, "_rdy2"}, 32'(hready), 32'd1);
    chk({tag, "_rsp2"}, 32'(hresp), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp",  32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_irq",    32'(irq), 32'd0);
    chk("rst_hsplit", 32'(hsplit), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    rd("r_ctrl", 3'd0, 32'd0);
    chk("r_okay", 32'({s_rdy, s_resp}), 32'b100);
    rd("r_load",   3'd1, 32'hFFFF_FFFF);
    rd("r_value",  3'd2, 32'hFFFF_FFFF);
    rd("r_status", 3'd3, 32'd0);
    rd("r_psc",    3'd4, 32'd0);

    // One-shot countdown with interrupt enabled
    wr(3'd1, 32'd3);
    wr(3'd4, 32'd1);
`ifdef TIMER_PRESCALER_EN
    rd("os_psc", 3'd4, 32'd1);
    wr(3'd0, 32'h5);
    rd("os_v3", 3'd2, 32'd3);
    rd("os_v2", 3'd2, 32'd2);
    rd("os_v1", 3'd2, 32'd1);
    rd("os_v0", 3'd2, 32'd0);
    chk("os_irq_pre", 32'(s_irq), 32'd0);
`else
    rd("os_psc", 3'd4, 32'd0);
    wr(3'd0, 32'h5);
    rd("os_v2", 3'd2, 32'd2);
    rd("os_v0", 3'd2, 32'd0);
    chk("os_irq_pre", 32'(s_irq), 32'd0);
`endif
    rd("os_stat", 3'd3, 32'd1);
    chk("os_irq", 32'(s_irq), 32'd1);
    rd("os_ctrl", 3'd0, 32'd4);
    rd("os_vhold", 3'd2, 32'd0);

    // Clearing STATUS with no expiry in the same cycle drops irq
    wr(3'd3, 32'd1);
    rd("clr_stat", 3'd3, 32'd0);
    chk("clr_irq", 32'(s_irq), 32'd0);

    // Periodic reload, with a tick every clock
    wr(3'd4, 32'd0);
    wr(3'd1, 32'd2);
    wr(3'd0, 32'h7);
    rd("pr_v1a", 3'd2, 32'd1);
    rd("pr_v2a", 3'd2, 32'd2);
    rd("pr_v0a", 3'd2, 32'd0);
    rd("pr_v1b", 3'd2, 32'd1);
    rd("pr_v2b", 3'd2, 32'd2);
    // This W1C commits on an expiry edge, so the set wins
    wr(3'd3, 32'd1);
    rd("w1c_race", 3'd3, 32'd1);
    chk("w1c_race_irq", 32'(s_irq), 32'd1);
    // This W1C commits between expiries, so irq falls right after it
    wr(3'd3, 32'd1);
    chk("w1c_irq_pre", 32'(s_irq), 32'd1);
    rd("w1c_stat", 3'd3, 32'd0);
    chk("w1c_irq", 32'(s_irq), 32'd0);

    // Illegal transfers with the counter stopped
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd9);
    err_xfer("e_idx6", 1'b0, 3'd6, 3'b010, 32'h0);
    err_xfer("e_size", 1'b1, 3'd1, 3'b000, 32'h55);
    err_xfer("e_wval", 1'b1, 3'd2, 3'b010, 32'h77);
    err_xfer("e_idx7", 1'b1, 3'd7, 3'b010, 32'h1);
    rd("e_load", 3'd1, 32'd9);
    chk("e_okay", 32'({s_rdy, s_resp}), 32'b100);
    rd("e_value", 3'd2, 32'd9);
    rd("e_ctrl",  3'd0, 32'd0);

    // Reset mid-count, in the middle of an address phase
    wr(3'd1, 32'd7);
    wr(3'd0, 32'd1);
    rd("mr_v6", 3'd2, 32'd6);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h4;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_hready", 32'(hready), 32'd1);
    chk("mr_hrdata", hrdata, 32'd0);
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1; rst = 1'b0;
    rd("mr_value", 3'd2, 32'hFFFF_FFFF);
    rd("mr_load",  3'd1, 32'hFFFF_FFFF);
    rd("mr_ctrl",  3'd0, 32'd0);
    rd("mr_stat",  3'd3, 32'd0);
    rd("mr_psc",   3'd4, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
